// File: rtl/spi_pkg.sv
// SPI receive front-end shared definitions.
// Mode encodings, FSM state type and default word width.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin,
// with rise/fall pulses from a previous-value register.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic srst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge i_clk) begin
    if (srst) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], async_in};
      prev <= sr[STAGES-1];
    end
  end

  assign sync_out = sr[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversampled pins, bit assembly,
// FIFO push with overflow/frame-error status.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              srst,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic [DATA_W-1:0] o_fifo_din,
  output logic              o_fifo_wr_en,
  input  logic              i_fifo_full,
  input  logic              i_fifo_rst_busy,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_frame_err,
  output logic [7:0]        o_drop_cnt,
  input  logic              i_clr_status
);

  localparam int         CW   = $clog2(DATA_W);
  localparam int         AW   = $clog2(SYNC_STAGES + 1);
  localparam logic       IDLE_POL = (CPOL != 0);

  state_e state, state_nxt;

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] sh, sh_nxt, byte_q;
  logic [AW-1:0]     arm_cnt;
  logic arm_done, sample, shift_ev, last;
  logic byte_done, drop, ferr_set;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (IDLE_POL)
  ) u_sclk_sync (
    .i_clk    (i_clk),
    .srst     (srst),
    .async_in (i_sclk),
    .sync_out (sclk_q),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .i_clk    (i_clk),
    .srst     (srst),
    .async_in (i_cs_n),
    .sync_out (cs_q),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  always_ff @(posedge i_clk) begin
    if (srst) mosi_sr <= '0;
    else      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], i_mosi};
  end

  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  // Synchronizers hold preset values right after reset; let them flush.
  assign arm_done = (arm_cnt == AW'(SYNC_STAGES));

  always_ff @(posedge i_clk) begin
    if (srst) state <= ARM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARM:     if (arm_done && cs_q) state_nxt = IDLE;
      IDLE:    if (cs_fall)          state_nxt = SHIFT;
      SHIFT:   if (cs_rise)          state_nxt = IDLE;
      default:                       state_nxt = ARM;
    endcase
  end

  assign sample   = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign shift_ev = (state == SHIFT) && sample;
  assign last     = (cnt == CW'(DATA_W - 1));

  always_comb begin
    cnt_nxt = cnt;
    sh_nxt  = sh;
    if (shift_ev) begin
      cnt_nxt = last ? '0 : cnt + 1'b1;
      sh_nxt  = (MSB_FIRST != 0) ? {sh[DATA_W-2:0], mosi_q}
                                 : {mosi_q, sh[DATA_W-1:1]};
    end
  end

  // A byte completing in the same cycle as CS_N rise leaves cnt_nxt at 0.
  assign ferr_set = (state == SHIFT) && cs_rise && (cnt_nxt != '0);
  assign drop     = byte_done && (i_fifo_full || i_fifo_rst_busy);

  always_ff @(posedge i_clk) begin
    if (srst) begin
      arm_cnt      <= '0;
      cnt          <= '0;
      sh           <= '0;
      byte_q       <= '0;
      byte_done    <= 1'b0;
      o_fifo_din   <= '0;
      o_fifo_wr_en <= 1'b0;
      o_overflow   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      byte_done    <= 1'b0;
      o_fifo_wr_en <= 1'b0;
      if (state == ARM && !arm_done) arm_cnt <= arm_cnt + 1'b1;
      if (state == IDLE && cs_fall) begin
        cnt <= '0;
        sh  <= '0;
      end
      if (shift_ev) begin
        cnt <= cnt_nxt;
        sh  <= sh_nxt;
        if (last) begin
          byte_done <= 1'b1;
          byte_q    <= sh_nxt;
        end
      end
      if (byte_done && !drop) begin
        o_fifo_wr_en <= 1'b1;
        o_fifo_din   <= byte_q;
      end
      if (i_clr_status) begin
        o_overflow  <= 1'b0;
        o_frame_err <= 1'b0;
        o_drop_cnt  <= '0;
      end
      if (drop) begin
        o_overflow <= 1'b1;
        if (i_clr_status)             o_drop_cnt <= 8'd1;
        else if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
      if (ferr_set) o_frame_err <= 1'b1;
    end
  end

  assign o_busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: five instances covering modes 0-3
// and LSB-first, scoreboard of expected FIFO writes.
module tb_spi_slave_rx;

  localparam logic [4:0] CPOL_V = 5'b01100;
  localparam logic [4:0] CPHA_V = 5'b01010;
  localparam logic [4:0] MSB_V  = 5'b01111;
  localparam int         LAT    = 4;

  typedef struct {
    int         k;
    logic [7:0] d;
    longint     c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       srst;
  logic [4:0] sclk_v;
  logic [4:0] cs_v;
  logic       mosi;
  logic       full;
  logic       rst_busy;
  logic       clr;
  logic [7:0] din [5];
  logic [7:0] dcnt [5];
  logic [4:0] wr_en, busy, ovf, ferr;

  longint     cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         clr_on_last = 0;
  exp_t       sb [$];
  logic [7:0] fifo_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    spi_slave_rx #(
      .DATA_W      (8),
      .CPOL        (int'(CPOL_V[g])),
      .CPHA        (int'(CPHA_V[g])),
      .MSB_FIRST   (int'(MSB_V[g])),
      .SYNC_STAGES (2)
    ) u_dut (
      .i_clk           (clk),
      .srst            (srst),
      .i_sclk          (sclk_v[g]),
      .i_cs_n          (cs_v[g]),
      .i_mosi          (mosi),
      .o_fifo_din      (din[g]),
      .o_fifo_wr_en    (wr_en[g]),
      .i_fifo_full     (g == 0 ? full : 1'b0),
      .i_fifo_rst_busy (g == 0 ? rst_busy : 1'b0),
      .o_busy          (busy[g]),
      .o_overflow      (ovf[g]),
      .o_frame_err     (ferr[g]),
      .o_drop_cnt      (dcnt[g]),
      .i_clr_status    (clr)
    );
  end

  task automatic chk(string tag, longint obs, longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (wr_en[k]) begin
        exp_t e;
        if (k == 0) fifo_q.push_back(din[0]);
        chk("sb_has_entry", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_dut", k, e.k);
          chk("wr_din", din[k], e.d);
          chk("latency", cyc - e.c0, LAT);
        end
      end
    end
  end

  task automatic wc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic note(bit lst, int k, logic [7:0] v, bit push);
    if (lst && push) sb.push_back('{k, v, cyc});
    if (lst && clr_on_last) begin
      fork
        begin
          repeat (3) @(posedge clk);
          #1 clr = 1'b1;
          @(posedge clk);
          #1 clr = 1'b0;
        end
      join_none
    end
  endtask

  task automatic send_bits(int k, logic [7:0] v, int nb, bit push);
    logic pol, pha, b;
    pol = CPOL_V[k];
    pha = CPHA_V[k];
    for (int i = 0; i < nb; i++) begin
      b = MSB_V[k] ? v[7-i] : v[i];
      if (!pha) begin
        mosi = b;
        wc(3);
        sclk_v[k] = ~pol;
        note(i == nb - 1, k, v, push);
        wc(5);
        sclk_v[k] = pol;
        wc(2);
      end else begin
        sclk_v[k] = ~pol;
        mosi = b;
        wc(5);
        sclk_v[k] = pol;
        note(i == nb - 1, k, v, push);
        wc(5);
      end
    end
  endtask

  task automatic cs_low(int k);
    cs_v[k] = 1'b0;
    wc(4);
  endtask

  task automatic cs_high(int k);
    wc(3);
    cs_v[k] = 1'b1;
    wc(6);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    wc(1);
    clr = 1'b0;
    wc(1);
  endtask

  initial begin
    srst = 1'b1;
    sclk_v = CPOL_V;
    cs_v = '1;
    mosi = 1'b0;
    full = 1'b0;
    rst_busy = 1'b1;
    clr = 1'b0;
    wc(4);
    chk("rst_wr_en", wr_en[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_ferr", ferr[0], 0);
    chk("rst_dcnt", dcnt[0], 0);
    chk("rst_din", din[0], 0);
    srst = 1'b0;
    wc(10);
    rst_busy = 1'b0;
    wc(5);

    // single byte, mode 0
    cs_low(0);
    chk("t1_busy_hi", busy[0], 1);
    send_bits(0, 8'hA5, 8, 1);
    cs_high(0);
    chk("t1_busy_lo", busy[0], 0);
    chk("t1_ovf", ovf[0], 0);
    chk("t1_ferr", ferr[0], 0);

    // back-to-back bytes into FIFO model
    fifo_q.delete();
    cs_low(0);
    for (int i = 0; i < 8; i++) send_bits(0, 8'(i + 2), 8, 1);
    cs_high(0);
    chk("t2_fifo_cnt", fifo_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (fifo_q.size() > 0) chk("t2_readback", fifo_q.pop_front(), i + 2);
    end

    // drops while FIFO full
    full = 1'b1;
    cs_low(0);
    send_bits(0, 8'h3C, 8, 0);
    send_bits(0, 8'h3D, 8, 0);
    cs_high(0);
    full = 1'b0;
    chk("t3_ovf", ovf[0], 1);
    chk("t3_dcnt", dcnt[0], 2);
    pulse_clr();
    chk("t3_ovf_clr", ovf[0], 0);
    chk("t3_dcnt_clr", dcnt[0], 0);

    // drops while FIFO reset busy; clear coinciding with a drop
    rst_busy = 1'b1;
    cs_low(0);
    send_bits(0, 8'h55, 8, 0);
    wc(10);
    chk("t3b_ovf", ovf[0], 1);
    chk("t3b_dcnt", dcnt[0], 1);
    clr_on_last = 1;
    send_bits(0, 8'h56, 8, 0);
    clr_on_last = 0;
    cs_high(0);
    rst_busy = 1'b0;
    chk("t3b_clr_drop_ovf", ovf[0], 1);
    chk("t3b_clr_drop_dcnt", dcnt[0], 1);
    pulse_clr();

    // partial byte then a good frame
    cs_low(0);
    send_bits(0, 8'hFF, 5, 0);
    cs_high(0);
    chk("t4_ferr", ferr[0], 1);
    cs_low(0);
    send_bits(0, 8'h11, 8, 1);
    cs_high(0);

    // srst mid-frame
    cs_low(0);
    send_bits(0, 8'hE0, 3, 0);
    srst = 1'b1;
    wc(1);
    srst = 1'b0;
    chk("t5_busy_rst", busy[0], 0);
    chk("t5_ferr_rst", ferr[0], 0);
    send_bits(0, 8'hFF, 5, 0);
    cs_high(0);
    cs_low(0);
    send_bits(0, 8'h77, 8, 1);
    cs_high(0);
    chk("t5_ferr", ferr[0], 0);

    // other modes and LSB-first
    for (int k = 1; k < 5; k++) begin
      cs_low(k);
      chk("t6_busy_hi", busy[k], 1);
      send_bits(k, 8'hA5, 8, 1);
      cs_high(k);
      chk("t6_busy_lo", busy[k], 0);
      chk("t6_ferr", ferr[k], 0);
    end

    // drop counter saturation
    full = 1'b1;
    cs_low(0);
    for (int i = 0; i < 256; i++) send_bits(0, 8'(i), 8, 0);
    cs_high(0);
    full = 1'b0;
    chk("t7_dcnt_sat", dcnt[0], 255);
    chk("t7_ovf", ovf[0], 1);

    wc(20);
    chk("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
